// File: rtl/fc_layer_engine.sv
// Time-multiplexed fully-connected layer: LANES neurons per group share one pass over x,
// then bias, optional ReLU and saturation, and results stream out over a valid/ready port.
module fc_layer_engine #(
    parameter int IN_LEN  = 132,
    parameter int OUT_LEN = 10,
    parameter int LANES   = 2,
    parameter int DW      = 8,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 24,
    localparam int IA_W   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    localparam int WA_W   = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    localparam int OA_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_wr,
    input  logic [IA_W-1:0]         in_addr,
    input  logic signed [DW-1:0]    in_data,
    input  logic                    w_wr,
    input  logic [WA_W-1:0]         w_addr,
    input  logic signed [DW-1:0]    w_data,
    input  logic                    b_wr,
    input  logic [OA_W-1:0]         b_addr,
    input  logic signed [ACC_W-1:0] b_data,
    input  logic                    relu_en,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OA_W-1:0]         out_idx,
    output logic signed [OUT_W-1:0] out_data
);
    localparam int G  = OUT_LEN / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IA_W-1:0] K_LAST = IA_W'(IN_LEN - 1);
    localparam logic [GW-1:0]   G_LAST = GW'(G - 1);
    localparam logic [LW-1:0]   L_LAST = LW'(LANES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_MAC, S_BIAS, S_EMIT, S_DONE} state_t;

    function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] v,
                                                         input logic relu);
        logic signed [ACC_W-1:0] r;
        r = (relu && v[ACC_W-1]) ? '0 : v;
        if (r > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    logic signed [DW-1:0]    x_mem [IN_LEN];
    logic signed [DW-1:0]    w_mem [IN_LEN*OUT_LEN];
    logic signed [ACC_W-1:0] b_mem [OUT_LEN];

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d, relu_q, relu_d;
    logic                    out_valid_q, out_valid_d;
    logic [OA_W-1:0]         out_idx_q, out_idx_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic [IA_W-1:0]         k_q, k_d, rd_k;
    logic [GW-1:0]           g_q, g_d;
    logic [LW-1:0]           lane_q, lane_d, nxt_lane;
    logic                    rd_en;

    logic signed [DW-1:0]    x_rd_q;
    logic signed [DW-1:0]    w_rd_q [LANES];
    logic signed [ACC_W-1:0] b_rd_q [LANES];
    logic [WA_W-1:0]         w_idx [LANES];
    logic [OA_W-1:0]         b_idx [LANES];
    logic signed [2*DW-1:0]  prod [LANES];
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic signed [OUT_W-1:0] res_q [LANES];
    logic signed [OUT_W-1:0] res_d [LANES];

    // Read for element k is issued one cycle ahead of the MAC that consumes it.
    always_comb begin
        rd_en = (state_q == S_PRIME) || ((state_q == S_MAC) && (k_q != K_LAST));
        rd_k  = (state_q == S_PRIME) ? '0 : IA_W'(k_q + 1'b1);
        for (int l = 0; l < LANES; l++) begin
            w_idx[l] = WA_W'((int'(g_q) * LANES + l) * IN_LEN + int'(rd_k));
            b_idx[l] = OA_W'(int'(g_q) * LANES + l);
            prod[l]  = x_rd_q * w_rd_q[l];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        relu_d      = relu_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        k_d         = k_q;
        g_d         = g_q;
        lane_d      = lane_q;
        nxt_lane    = lane_q + 1'b1;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
            res_d[l] = res_q[l];
        end
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_PRIME;
                busy_d  = 1'b1;
                relu_d  = relu_en;
                g_d     = '0;
            end
            S_PRIME: begin
                k_d = '0;
                for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                for (int l = 0; l < LANES; l++)
                    acc_d[l] = acc_q[l] + {{(ACC_W-2*DW){prod[l][2*DW-1]}}, prod[l]};
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) state_d = S_BIAS;
            end
            S_BIAS: begin
                for (int l = 0; l < LANES; l++)
                    res_d[l] = relu_sat(acc_q[l] + b_rd_q[l], relu_q);
                lane_d      = '0;
                out_valid_d = 1'b1;
                out_idx_d   = OA_W'(int'(g_q) * LANES);
                out_data_d  = res_d[0];
                state_d     = S_EMIT;
            end
            S_EMIT: if (out_ready) begin
                if (lane_q == L_LAST) begin
                    out_valid_d = 1'b0;
                    if (g_q == G_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        g_d     = g_q + 1'b1;
                        state_d = S_PRIME;
                    end
                end else begin
                    lane_d     = nxt_lane;
                    out_idx_d  = out_idx_q + 1'b1;
                    out_data_d = res_q[nxt_lane];
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            k_q         <= '0;
            g_q         <= '0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            k_q         <= k_d;
            g_q         <= g_d;
            lane_q      <= lane_d;
        end
    end

    // Memories and datapath registers carry no reset; writes are locked out while busy.
    always_ff @(posedge clk) begin
        if (in_wr && !busy_q && int'(in_addr) < IN_LEN) x_mem[in_addr] <= in_data;
        if (w_wr && !busy_q && int'(w_addr) < IN_LEN * OUT_LEN) w_mem[w_addr] <= w_data;
        if (b_wr && !busy_q && int'(b_addr) < OUT_LEN) b_mem[b_addr] <= b_data;
        if (rd_en) x_rd_q <= x_mem[rd_k];
        for (int l = 0; l < LANES; l++) begin
            if (rd_en) w_rd_q[l] <= w_mem[w_idx[l]];
            b_rd_q[l] <= b_mem[b_idx[l]];
            acc_q[l]  <= acc_d[l];
            res_q[l]  <= res_d[l];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine: the stimulus process queues expected results,
// a negedge monitor pops and compares on every handshake and checks hold stability.
module tb_fc_layer_engine;
    localparam int IN_LEN  = 132;
    localparam int OUT_LEN = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_wr;
    logic [7:0]         in_addr;
    logic signed [7:0]  in_data;
    logic               w_wr;
    logic [10:0]        w_addr;
    logic signed [7:0]  w_data;
    logic               b_wr;
    logic [3:0]         b_addr;
    logic signed [31:0] b_data;
    logic               relu_en;
    logic               start;
    logic               busy;
    logic               done;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_idx;
    logic signed [23:0] out_data;

    int total = 0;
    int bad   = 0;
    int dones = 0;
    int exp_idx[$];
    int exp_data[$];
    bit rnd_ready = 1'b0;
    bit hold = 1'b0;
    int h_idx, h_data;
    int std_exp[10], zero_exp[10], neg_exp[10], big_exp[10];

    fc_layer_engine dut (
        .clk(clk), .rst(rst),
        .in_wr(in_wr), .in_addr(in_addr), .in_data(in_data),
        .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
        .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data),
        .relu_en(relu_en), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int ei, ed;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_idx", longint'(out_idx), h_idx);
                chk("hold_data", longint'(out_data), h_data);
            end
            hold = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_idx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: idx %0d data %0d with nothing expected",
                             out_idx, out_data);
                end else begin
                    ei = exp_idx.pop_front();
                    ed = exp_data.pop_front();
                    chk("out_idx", longint'(out_idx), ei);
                    chk("out_data", longint'(out_data), ed);
                end
            end else if (out_valid) begin
                hold   = 1'b1;
                h_idx  = int'(out_idx);
                h_data = int'(out_data);
            end
            if (done) begin
                dones++;
                chk("done_after_last_handshake", exp_idx.size(), 0);
            end
        end
    end

    task automatic load_x(input int kind);
        for (int k = 0; k < IN_LEN; k++) begin
            in_wr   = 1'b1;
            in_addr = 8'(k);
            in_data = (kind == 0) ? 8'((k % 8) - 3) : 8'sd127;
            @(posedge clk); #1;
        end
        in_wr = 1'b0;
    endtask

    task automatic load_w(input int kind);
        for (int n = 0; n < OUT_LEN; n++)
            for (int k = 0; k < IN_LEN; k++) begin
                w_wr   = 1'b1;
                w_addr = 11'(n * IN_LEN + k);
                w_data = (kind == 0) ? 8'(n + 1) : (kind == 1) ? 8'(-(n + 1)) : 8'sd127;
                @(posedge clk); #1;
            end
        w_wr = 1'b0;
    endtask

    task automatic load_b(input int b0, input int b1);
        for (int n = 0; n < OUT_LEN; n++) begin
            b_wr   = 1'b1;
            b_addr = 4'(n);
            b_data = (n == 0) ? b0 : (n == 1) ? b1 : 0;
            @(posedge clk); #1;
        end
        b_wr = 1'b0;
    endtask

    task automatic run(input bit relu, input int expd[10], input int lat, input int poke);
        int cyc;
        bit seen;
        for (int n = 0; n < OUT_LEN; n++) begin
            exp_idx.push_back(n);
            exp_data.push_back(expd[n]);
        end
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        relu_en = ~relu;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            if (cyc == poke) begin
                start = 1'b1;
                w_wr = 1'b1;  w_addr = 11'd1188; w_data = -8'sd50;
                in_wr = 1'b1; in_addr = 8'd100;  in_data = 8'sd55;
                b_wr = 1'b1;  b_addr = 4'd9;     b_data = 32'sd777;
            end else begin
                start = 1'b0; w_wr = 1'b0; in_wr = 1'b0; b_wr = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0; w_wr = 1'b0; in_wr = 1'b0; b_wr = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles, %0d results outstanding",
                     cyc, exp_idx.size());
            exp_idx.delete();
            exp_data.delete();
        end else begin
            chk("busy_at_done", longint'(busy), 0);
            if (lat >= 0) chk("done_latency", cyc, lat);
        end
        @(posedge clk); #1;
        chk("done_pulse_width", longint'(done), 0);
    endtask

    initial begin
        int d0;
        rst = 1'b0; in_wr = 1'b0; w_wr = 1'b0; b_wr = 1'b0;
        in_addr = '0; in_data = '0; w_addr = '0; w_data = '0; b_addr = '0; b_data = '0;
        relu_en = 1'b0; start = 1'b0;
        for (int n = 0; n < OUT_LEN; n++) begin
            std_exp[n]  = 58 * (n + 1);
            neg_exp[n]  = -58 * (n + 1);
            zero_exp[n] = 0;
            big_exp[n]  = 2129028;
        end
        big_exp[0] = 8388607;
        big_exp[1] = -8388608;

        #1 rst = 1'b1;
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_idx", longint'(out_idx), 0);
        chk("reset_out_data", longint'(out_data), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        load_x(0);
        in_wr = 1'b1; in_addr = 8'd132; in_data = 8'sd100;
        @(posedge clk); #1;
        in_wr = 1'b0;
        load_w(0);
        load_b(0, 0);
        run(1'b1, std_exp, 681, -1);

        rnd_ready = 1'b1;
        run(1'b1, std_exp, -1, -1);
        rnd_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        run(1'b1, std_exp, 681, 30);

        relu_en = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", longint'(busy), 0);
        chk("midrun_rst_out_valid", longint'(out_valid), 0);
        chk("midrun_rst_done", longint'(done), 0);
        chk("midrun_rst_out_idx", longint'(out_idx), 0);
        chk("midrun_rst_out_data", longint'(out_data), 0);
        d0 = dones;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("no_done_after_rst", dones, d0);
        chk("idle_after_rst", longint'(busy), 0);
        run(1'b1, std_exp, 681, -1);

        load_w(1);
        run(1'b1, zero_exp, 681, -1);
        run(1'b0, neg_exp, 681, -1);

        load_x(1);
        load_w(2);
        load_b(8000000, -20000000);
        run(1'b0, big_exp, 681, -1);

        repeat (3) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
